kilit_denetleyici: RTL and testbench
====================================

KILIT_DENETLEYICI -- requirements
Module: kilit_denetleyici

Interface
REQ-001 Parameter ADIM_SAG, default 5: dial positions advanced per right step.
REQ-002 Parameter ADIM_SOL, default 10: dial positions retreated per left step.
REQ-003 Parameter ACIK_SURESI, default 8: cycles the lock stays open.
REQ-004 Parameter KILIT_SURESI, default 16: lockout duration in cycles.
REQ-005 Parameter VARSAYILAN_SIFRE, default {6'd5,6'd30,6'd15}: reset combination; digit0 is in the MSB field.
REQ-006 Ports SHALL be:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
hamle_gecerli  in  1  move strobe.
sag_adim  in  3  right steps, 0-7.
sol_adim  in  2  left steps, 0-3.
onayla  in  1  confirm current position as the next digit.
sifre_yukle  in  1  load a new combination.
yeni_sifre  in  18  three 6-bit digits {d0,d1,d2}.
konum  out  6  dial position, 0-39.
hane  out  2  index of the expected digit, 0-2.
hata_sayisi  out  2  consecutive failed attempts.
kilit_acik  out  1  lock open.
kilitlendi  out  1  lockout active.

Function
REQ-007 The FSM SHALL have states BEKLE (entering digits), ACIK and KILITLI.
REQ-008 In BEKLE with hamle_gecerli=1, konum SHALL become (konum + ADIM_SAG*sag_adim - ADIM_SOL*sol_adim) mod 40 on the next edge.
- Compute in a 7-bit intermediate: konum + ADIM_SAG*sag + 40 - ADIM_SOL*sol.
- Reduce by at most two conditional subtractions of 40.
REQ-009 In BEKLE with onayla=1, the registered konum SHALL be compared with digit[hane].
- The comparison uses the pre-move value even when hamle_gecerli is high in the same cycle.
- The move is still applied in that cycle.
REQ-010 On a match with hane<2, hane SHALL increment.
REQ-011 On a match with hane=2, the FSM SHALL enter ACIK, hane SHALL clear to 0 and hata_sayisi SHALL clear to 0.
- kilit_acik rises on the cycle after the confirming edge.
REQ-012 On a mismatch, hane SHALL clear to 0 and hata_sayisi SHALL increment.
- If the increment reaches 3, the FSM SHALL enter KILITLI.
REQ-013 ACIK SHALL last exactly ACIK_SURESI cycles with kilit_acik=1, then return to BEKLE; konum is retained.
REQ-014 KILITLI SHALL last exactly KILIT_SURESI cycles with kilitlendi=1, then return to BEKLE with hata_sayisi=0.
REQ-015 In ACIK and KILITLI, hamle_gecerli and onayla SHALL be ignored.
REQ-016 sifre_yukle SHALL take effect only in ACIK.
- If any field of yeni_sifre is >=40, the whole load SHALL be ignored and the stored combination kept.
- In all other states sifre_yukle SHALL be ignored.
REQ-017 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL set: state BEKLE, konum=0, hane=0, hata_sayisi=0, kilit_acik=0, kilitlendi=0, combination=VARSAYILAN_SIFRE, timers=0.
REQ-019 A reset asserted during ACIK or KILITLI SHALL abort that state immediately; outputs take their reset values on the next edge.
REQ-020 A combination loaded before the reset SHALL be lost.

Configuration
REQ-021 Macro KILIT_DENETLEYICI_KILITLEME_EN SHALL control the lockout feature.
- Defined: behaviour is as REQ-012/REQ-014.
- Undefined: KILITLI does not exist, kilitlendi is tied to 0, and hata_sayisi saturates at 3 without locking.

Structure
REQ-022 Package kilit_pkg SHALL hold the state enum, KONUM_SAYISI=40 and the 6-bit digit typedef.
REQ-023 Sub-module kilit_kadran SHALL contain the konum register and the mod-40 update (REQ-008).
- The FSM, timers and combination storage SHALL stay in the top level.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset; then sag=1; onayla; sag=5; onayla; sag=1,sol=2; onayla -> konum goes 5, 30, 15; kilit_acik=1 for exactly 8 cycles; hata_sayisi=0.
- Reset; onayla at konum=0 -> hata_sayisi=1, hane=0; repeat twice -> kilitlendi=1 for 16 cycles, then hata_sayisi=0.
- Without the macro: three mismatches -> hata_sayisi=3 and kilitlendi=0; a fourth mismatch leaves hata_sayisi=3.
- konum=35 with sag=7 -> konum=30; konum=0 with sol=3 -> konum=10; all 32 sag/sol pairs from konum=0 match the (5*sag-10*sol) mod 40 table.
- In ACIK, sifre_yukle with {6'd10,6'd20,6'd0} -> the new code opens the lock; yeni_sifre {6'd45,...} -> ignored; sifre_yukle in BEKLE -> ignored.
- onayla with hamle_gecerli in the same cycle at konum=5 (digit0=5) -> match, and konum updates; rst_n low mid-ACIK -> kilit_acik=0 on the next edge and combination=default.

Source files
------------

// File: rtl/kilit_pkg.sv
// Shared types for the combination lock: dial size, digit type, FSM states.
// The KILITLI state exists only when KILIT_DENETLEYICI_KILITLEME_EN is defined.
package kilit_pkg;

  localparam int unsigned KONUM_SAYISI = 40;

  typedef logic [5:0] hane_t;

`ifdef KILIT_DENETLEYICI_KILITLEME_EN
  typedef enum logic [1:0] {
    BEKLE   = 2'd0,
    ACIK    = 2'd1,
    KILITLI = 2'd2
  } durum_t;
`else
  typedef enum logic [1:0] {
    BEKLE = 2'd0,
    ACIK  = 2'd1
  } durum_t;
`endif

  // Digit 0 sits in the most significant field.
  function automatic hane_t sifre_hanesi(input logic [17:0] sifre, input logic [1:0] idx);
    case (idx)
      2'd0:    sifre_hanesi = sifre[17:12];
      2'd1:    sifre_hanesi = sifre[11:6];
      default: sifre_hanesi = sifre[5:0];
    endcase
  endfunction

  function automatic logic sifre_gecerli(input logic [17:0] sifre);
    sifre_gecerli = (sifre[17:12] < 6'(KONUM_SAYISI)) &&
                    (sifre[11:6]  < 6'(KONUM_SAYISI)) &&
                    (sifre[5:0]   < 6'(KONUM_SAYISI));
  endfunction

endpackage

// File: rtl/kilit_kadran.sv
// Dial position register with a mod-40 update from right/left step counts.
module kilit_kadran
  import kilit_pkg::*;
#(
  parameter int unsigned ADIM_SAG = 5,
  parameter int unsigned ADIM_SOL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hamle,
  input  logic [2:0] i_sag,
  input  logic [1:0] i_sol,
  output hane_t      o_konum
);

  hane_t      r_konum;
  logic [6:0] w_ara;
  logic [6:0] w_bir;
  logic [6:0] w_iki;

  // Adding 40 up front keeps the intermediate non-negative before the left retreat.
  always_comb begin
    w_ara = 7'(r_konum) + 7'(ADIM_SAG * i_sag) + 7'(KONUM_SAYISI) - 7'(ADIM_SOL * i_sol);
    w_bir = (w_ara >= 7'(KONUM_SAYISI)) ? w_ara - 7'(KONUM_SAYISI) : w_ara;
    w_iki = (w_bir >= 7'(KONUM_SAYISI)) ? w_bir - 7'(KONUM_SAYISI) : w_bir;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_konum <= '0;
    end else if (i_hamle) begin
      r_konum <= 6'(w_iki);
    end
  end

  assign o_konum = r_konum;

endmodule

// File: rtl/kilit_denetleyici.sv
// Three-digit combination lock controller with open timer and optional lockout.
// Lockout is enabled by defining KILIT_DENETLEYICI_KILITLEME_EN.
module kilit_denetleyici
  import kilit_pkg::*;
#(
  parameter int unsigned ADIM_SAG         = 5,
  parameter int unsigned ADIM_SOL         = 10,
  parameter int unsigned ACIK_SURESI      = 8,
  parameter int unsigned KILIT_SURESI     = 16,
  parameter logic [17:0] VARSAYILAN_SIFRE = {6'd5, 6'd30, 6'd15}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hamle_gecerli,
  input  logic [2:0]  sag_adim,
  input  logic [1:0]  sol_adim,
  input  logic        onayla,
  input  logic        sifre_yukle,
  input  logic [17:0] yeni_sifre,
  output logic [5:0]  konum,
  output logic [1:0]  hane,
  output logic [1:0]  hata_sayisi,
  output logic        kilit_acik,
  output logic        kilitlendi
);

  localparam int unsigned EN_UZUN  = (ACIK_SURESI > KILIT_SURESI) ? ACIK_SURESI : KILIT_SURESI;
  localparam int unsigned SAYAC_W  = $clog2(EN_UZUN) + 1;

  durum_t               r_durum, w_durum_d;
  logic [1:0]           r_hane, w_hane_d;
  logic [1:0]           r_hata, w_hata_d;
  logic [SAYAC_W-1:0]   r_sayac, w_sayac_d;
  logic [17:0]          r_sifre, w_sifre_d;
  logic                 r_acik, w_acik_d;
  hane_t                w_konum;
  logic                 w_hamle;
  logic                 w_esles;

  assign w_hamle = hamle_gecerli && (r_durum == BEKLE);
  // Compared against the pre-move position, even if a move lands on this edge.
  assign w_esles = (w_konum == sifre_hanesi(r_sifre, r_hane));

  kilit_kadran #(
    .ADIM_SAG (ADIM_SAG),
    .ADIM_SOL (ADIM_SOL)
  ) u_kadran (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hamle (w_hamle),
    .i_sag   (sag_adim),
    .i_sol   (sol_adim),
    .o_konum (w_konum)
  );

  always_comb begin
    w_durum_d = r_durum;
    w_hane_d  = r_hane;
    w_hata_d  = r_hata;
    w_sayac_d = r_sayac;
    w_sifre_d = r_sifre;
    unique case (r_durum)
      BEKLE: begin
        if (onayla) begin
          if (w_esles) begin
            if (r_hane == 2'd2) begin
              w_durum_d = ACIK;
              w_hane_d  = 2'd0;
              w_hata_d  = 2'd0;
              w_sayac_d = '0;
            end else begin
              w_hane_d = r_hane + 2'd1;
            end
          end else begin
            w_hane_d = 2'd0;
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
            w_hata_d = r_hata + 2'd1;
            if (r_hata == 2'd2) begin
              w_durum_d = KILITLI;
              w_sayac_d = '0;
            end
`else
            if (r_hata != 2'd3) begin
              w_hata_d = r_hata + 2'd1;
            end
`endif
          end
        end
      end
      ACIK: begin
        if (sifre_yukle && sifre_gecerli(yeni_sifre)) begin
          w_sifre_d = yeni_sifre;
        end
        if (r_sayac == SAYAC_W'(ACIK_SURESI - 1)) begin
          w_durum_d = BEKLE;
          w_sayac_d = '0;
        end else begin
          w_sayac_d = r_sayac + 1'b1;
        end
      end
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
      KILITLI: begin
        if (r_sayac == SAYAC_W'(KILIT_SURESI - 1)) begin
          w_durum_d = BEKLE;
          w_hata_d  = 2'd0;
          w_sayac_d = '0;
        end else begin
          w_sayac_d = r_sayac + 1'b1;
        end
      end
`endif
      default: w_durum_d = BEKLE;
    endcase
  end

`ifdef KILIT_DENETLEYICI_KILITLEME_EN
  logic r_kilitli, w_kilitli_d;
`endif

  // Status flags follow the next state so they are registered alongside it.
  always_comb begin
    w_acik_d = (w_durum_d == ACIK);
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
    w_kilitli_d = (w_durum_d == KILITLI);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_durum <= BEKLE;
      r_hane  <= 2'd0;
      r_hata  <= 2'd0;
      r_sayac <= '0;
      r_sifre <= VARSAYILAN_SIFRE;
      r_acik  <= 1'b0;
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
      r_kilitli <= 1'b0;
`endif
    end else begin
      r_durum <= w_durum_d;
      r_hane  <= w_hane_d;
      r_hata  <= w_hata_d;
      r_sayac <= w_sayac_d;
      r_sifre <= w_sifre_d;
      r_acik  <= w_acik_d;
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
      r_kilitli <= w_kilitli_d;
`endif
    end
  end

  assign konum       = w_konum;
  assign hane        = r_hane;
  assign hata_sayisi = r_hata;
  assign kilit_acik  = r_acik;
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
  assign kilitlendi  = r_kilitli;
`else
  assign kilitlendi  = 1'b0;
`endif

endmodule

// File: tb/tb_kilit_denetleyici.sv
// Scoreboard bench for kilit_denetleyici: stimulus queues expected outputs, a
// negedge monitor pops and compares them.
module tb_kilit_denetleyici;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hamle_gecerli = 1'b0;
  logic [2:0]  sag_adim = 3'd0;
  logic [1:0]  sol_adim = 2'd0;
  logic        onayla = 1'b0;
  logic        sifre_yukle = 1'b0;
  logic [17:0] yeni_sifre = 18'd0;
  logic [5:0]  konum;
  logic [1:0]  hane;
  logic [1:0]  hata_sayisi;
  logic        kilit_acik;
  logic        kilitlendi;

  typedef struct packed {
    logic [5:0] k;
    logic [1:0] h;
    logic [1:0] ht;
    logic       a;
    logic       kl;
  } bek_t;

  bek_t q[$];
  bek_t m_b;
  int   checks = 0;
  int   errors = 0;
  int   n_item = 0;

`ifdef KILIT_DENETLEYICI_KILITLEME_EN
  localparam logic KL = 1'b1;
`else
  localparam logic KL = 1'b0;
`endif

  always #5 clk = ~clk;

  kilit_denetleyici dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hamle_gecerli (hamle_gecerli),
    .sag_adim      (sag_adim),
    .sol_adim      (sol_adim),
    .onayla        (onayla),
    .sifre_yukle   (sifre_yukle),
    .yeni_sifre    (yeni_sifre),
    .konum         (konum),
    .hane          (hane),
    .hata_sayisi   (hata_sayisi),
    .kilit_acik    (kilit_acik),
    .kilitlendi    (kilitlendi)
  );

  task automatic karsilastir(input string ad, input logic [7:0] gercek, input logic [7:0] bek);
    checks++;
    if (gercek !== bek) begin
      errors++;
      $display("FAIL item %0d %s: got %0d expected %0d", n_item, ad, gercek, bek);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_b = q.pop_front();
      karsilastir("konum", 8'(konum), 8'(m_b.k));
      karsilastir("hane", 8'(hane), 8'(m_b.h));
      karsilastir("hata_sayisi", 8'(hata_sayisi), 8'(m_b.ht));
      karsilastir("kilit_acik", 8'(kilit_acik), 8'(m_b.a));
      karsilastir("kilitlendi", 8'(kilitlendi), 8'(m_b.kl));
      n_item++;
    end
  end

  // One clock of stimulus; the expectation is for the outputs after this edge.
  task automatic tik(input int k, input int h, input int ht, input logic a, input logic kl);
    @(posedge clk);
    q.push_back({6'(k), 2'(h), 2'(ht), a, kl});
    @(negedge clk);
    hamle_gecerli = 1'b0;
    onayla        = 1'b0;
    sifre_yukle   = 1'b0;
    sag_adim      = 3'd0;
    sol_adim      = 2'd0;
  endtask

  task automatic hareket(input int s, input int l, input int k, input int h, input int ht,
                         input logic a, input logic kl);
    hamle_gecerli = 1'b1;
    sag_adim      = 3'(s);
    sol_adim      = 2'(l);
    tik(k, h, ht, a, kl);
  endtask

  task automatic onay(input int k, input int h, input int ht, input logic a, input logic kl);
    onayla = 1'b1;
    tik(k, h, ht, a, kl);
  endtask

  task automatic sifirla();
    rst_n = 1'b0;
    tik(0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int e;
    sifirla();

    // Default code 5-30-15 opens; moves/confirms ignored while open.
    hareket(1, 0, 5, 0, 0, 1'b0, 1'b0);
    onay(5, 1, 0, 1'b0, 1'b0);
    hareket(5, 0, 30, 1, 0, 1'b0, 1'b0);
    onay(30, 2, 0, 1'b0, 1'b0);
    hareket(1, 2, 15, 2, 0, 1'b0, 1'b0);
    onay(15, 0, 0, 1'b1, 1'b0);
    hamle_gecerli = 1'b1;
    sag_adim      = 3'd1;
    onayla        = 1'b1;
    tik(15, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tik(15, 0, 0, 1'b1, 1'b0);
    tik(15, 0, 0, 1'b0, 1'b0);

    // Reopen, then load an invalid code followed by 10-20-0.
    hareket(0, 1, 5, 0, 0, 1'b0, 1'b0);
    onay(5, 1, 0, 1'b0, 1'b0);
    hareket(5, 0, 30, 1, 0, 1'b0, 1'b0);
    onay(30, 2, 0, 1'b0, 1'b0);
    hareket(1, 2, 15, 2, 0, 1'b0, 1'b0);
    onay(15, 0, 0, 1'b1, 1'b0);
    sifre_yukle = 1'b1;
    yeni_sifre  = {6'd45, 6'd20, 6'd0};
    tik(15, 0, 0, 1'b1, 1'b0);
    sifre_yukle = 1'b1;
    yeni_sifre  = {6'd10, 6'd20, 6'd0};
    tik(15, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tik(15, 0, 0, 1'b1, 1'b0);
    tik(15, 0, 0, 1'b0, 1'b0);

    // New code 10-20-0 opens; reset mid-open restores defaults.
    hareket(1, 1, 10, 0, 0, 1'b0, 1'b0);
    onay(10, 1, 0, 1'b0, 1'b0);
    hareket(2, 0, 20, 1, 0, 1'b0, 1'b0);
    onay(20, 2, 0, 1'b0, 1'b0);
    hareket(0, 2, 0, 2, 0, 1'b0, 1'b0);
    onay(0, 0, 0, 1'b1, 1'b0);
    tik(0, 0, 0, 1'b1, 1'b0);
    sifirla();

    // Confirm and move together at konum=5: default digit0 matches, move applies.
    hareket(1, 0, 5, 0, 0, 1'b0, 1'b0);
    hamle_gecerli = 1'b1;
    sag_adim      = 3'd1;
    onayla        = 1'b1;
    tik(10, 1, 0, 1'b0, 1'b0);
    // Load in BEKLE is ignored; default code completes.
    sifre_yukle = 1'b1;
    yeni_sifre  = {6'd10, 6'd20, 6'd0};
    tik(10, 1, 0, 1'b0, 1'b0);
    hareket(4, 0, 30, 1, 0, 1'b0, 1'b0);
    onay(30, 2, 0, 1'b0, 1'b0);
    hareket(1, 2, 15, 2, 0, 1'b0, 1'b0);
    onay(15, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tik(15, 0, 0, 1'b1, 1'b0);
    tik(15, 0, 0, 1'b0, 1'b0);

    // Three failed attempts.
    sifirla();
    onay(0, 0, 1, 1'b0, 1'b0);
    hareket(1, 0, 5, 0, 1, 1'b0, 1'b0);
    onay(5, 1, 1, 1'b0, 1'b0);
    onay(5, 0, 2, 1'b0, 1'b0);
    onay(5, 1, 2, 1'b0, 1'b0);
    onay(5, 0, 3, 1'b0, KL);
`ifdef KILIT_DENETLEYICI_KILITLEME_EN
    hamle_gecerli = 1'b1;
    sag_adim      = 3'd1;
    onayla        = 1'b1;
    tik(5, 0, 3, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) tik(5, 0, 3, 1'b0, 1'b1);
    tik(5, 0, 0, 1'b0, 1'b0);
    onay(5, 1, 0, 1'b0, 1'b0);
`else
    hareket(1, 0, 10, 0, 3, 1'b0, 1'b0);
    onay(10, 0, 3, 1'b0, 1'b0);
`endif

    // Wrap boundaries.
    sifirla();
    hareket(7, 0, 35, 0, 0, 1'b0, 1'b0);
    hareket(7, 0, 30, 0, 0, 1'b0, 1'b0);
    sifirla();
    hareket(0, 3, 10, 0, 0, 1'b0, 1'b0);

    // All step pairs from konum=0.
    for (int s = 0; s < 8; s++) begin
      for (int l = 0; l < 4; l++) begin
        sifirla();
        e = 5 * s - 10 * l;
        if (e < 0) e = e + 40;
        hareket(s, l, e, 0, 0, 1'b0, 1'b0);
      end
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
